// File: rtl/ctrl_decode_stage_pkg.sv
// Shared RV32I decode encodings: opcode map, control-field encodings and the ID->EX bundle type.
package ctrl_decode_stage_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpMisc   = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmJ = 3'b011,
        ImmU = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        SrcARs1  = 2'b00,
        SrcAPc   = 2'b01,
        SrcAZero = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        AluAdd    = 2'b00,
        AluBranch = 2'b01,
        AluFunct  = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        alu_src_a_e  alu_src_a;
        logic        alu_src_b;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        logic        jump;
        logic        jump_reg;
        alu_op_e     alu_op;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// ID->EX handshake and decoded-control bundle between the IF/ID side, the decode stage and EX.
interface ctrl_decode_stage_if #(
    parameter int unsigned CNT_W = 8
);
    logic             flush_i;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic             RegWrite;
    logic [2:0]       ImmSrc;
    logic [1:0]       ALUSrcA;
    logic             ALUSrcB;
    logic             MemWrite;
    logic [1:0]       ResultSrc;
    logic             Branch;
    logic             Jump;
    logic             JumpReg;
    logic [1:0]       ALUOp;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [4:0]       rd;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output flush_i, in_valid, instr, out_ready,
        input  in_ready, out_valid, RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc,
               Branch, Jump, JumpReg, ALUOp, funct3, funct7b5, rd, illegal, illegal_cnt
    );

    modport slave (
        input  flush_i, in_valid, instr, out_ready,
        output in_ready, out_valid, RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc,
               Branch, Jump, JumpReg, ALUOp, funct3, funct7b5, rd, illegal, illegal_cnt
    );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Combinational RV32I decoder: instruction word -> control bundle with illegal detection.
// Define CTRL_DECODE_SYSTEM_EN to accept SYSTEM (ECALL/EBREAK and CSR ops) as legal.
module ctrl_decode_comb
    import ctrl_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    logic       unused_rs;
    ctrl_t      dec;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign f7        = instr[31:25];
    assign unused_rs = ^instr[24:15];

    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (opcode)
            OpLoad: begin
                bad            = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.result_src = ResMem;
            end
            OpStore: begin
                bad           = (f3 > 3'b010);
                dec.imm_src   = ImmS;
                dec.alu_src_b = 1'b1;
                dec.mem_write = 1'b1;
            end
            OpOp: begin
                bad           = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
                dec.reg_write = 1'b1;
                dec.alu_op    = AluFunct;
            end
            OpImm: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.alu_op    = AluFunct;
            end
            OpBranch: begin
                bad         = (f3[2:1] == 2'b01);
                dec.imm_src = ImmB;
                dec.branch  = 1'b1;
                dec.alu_op  = AluBranch;
            end
            OpJal: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = ImmJ;
                dec.alu_src_a  = SrcAPc;
                dec.alu_src_b  = 1'b1;
                dec.result_src = ResPc4;
                dec.jump       = 1'b1;
            end
            OpJalr: begin
                bad            = (f3 != 3'b000);
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.result_src = ResPc4;
                dec.jump       = 1'b1;
                dec.jump_reg   = 1'b1;
            end
            OpLui: begin
                dec.reg_write = 1'b1;
                dec.imm_src   = ImmU;
                dec.alu_src_a = SrcAZero;
                dec.alu_src_b = 1'b1;
            end
            OpAuipc: begin
                dec.reg_write = 1'b1;
                dec.imm_src   = ImmU;
                dec.alu_src_a = SrcAPc;
                dec.alu_src_b = 1'b1;
            end
            OpMisc: begin
            end
`ifdef CTRL_DECODE_SYSTEM_EN
            OpSystem: begin
                // funct3=000 is ECALL/EBREAK (no controls); 100 is unassigned
                if (f3 == 3'b100) begin
                    bad = 1'b1;
                end else if (f3 != 3'b000) begin
                    dec.reg_write = 1'b1;
                    dec.alu_src_a = SrcAZero;
                    dec.alu_src_b = 1'b1;
                end
            end
`endif
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec = '0;
        end
        dec.funct3   = f3;
        dec.funct7b5 = instr[30];
        dec.rd       = instr[11:7];
        dec.illegal  = bad;
    end

    assign ctrl = dec;

endmodule

// File: rtl/ctrl_decode_stage.sv
// RV32I decode stage: decoder feeding an elastic ID->EX buffer plus a saturating illegal counter.
// SYSTEM legality follows CTRL_DECODE_SYSTEM_EN inside ctrl_decode_comb.
module ctrl_decode_stage
    import ctrl_decode_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    ctrl_decode_stage_if.slave bus
);
    ctrl_t            dec;
    ctrl_t            head_q, head_d;
    ctrl_t            tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [1:0]       slot;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    ctrl_decode_comb u_dec (
        .instr (bus.instr),
        .ctrl  (dec)
    );

    assign out_valid = (count_q != 2'd0);

    generate
        if (DEPTH == 1) begin : g_depth1
            assign in_ready = !out_valid || bus.out_ready;
        end else begin : g_depth2
            assign in_ready = ready_q;
        end
    endgenerate

    assign push = bus.in_valid && in_ready && !bus.flush_i;
    assign pop  = out_valid && bus.out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        // Slot the incoming entry lands in once this cycle's pop has shifted the queue
        slot    = count_q - {1'b0, pop};
        if (bus.flush_i) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop && (count_q == 2'd2)) begin
                head_d = tail_q;
            end
            if (push) begin
                if (slot == 2'd0) begin
                    head_d = dec;
                end else begin
                    tail_d = dec;
                end
            end
        end
        if (push && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        ready_d = (count_d != 2'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.RegWrite    = head_q.reg_write;
    assign bus.ImmSrc      = head_q.imm_src;
    assign bus.ALUSrcA     = head_q.alu_src_a;
    assign bus.ALUSrcB     = head_q.alu_src_b;
    assign bus.MemWrite    = head_q.mem_write;
    assign bus.ResultSrc   = head_q.result_src;
    assign bus.Branch      = head_q.branch;
    assign bus.Jump        = head_q.jump;
    assign bus.JumpReg     = head_q.jump_reg;
    assign bus.ALUOp       = head_q.alu_op;
    assign bus.funct3      = head_q.funct3;
    assign bus.funct7b5    = head_q.funct7b5;
    assign bus.rd          = head_q.rd;
    assign bus.illegal     = head_q.illegal;
    assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench: DEPTH=2/CNT_W=8 instance plus a DEPTH=1/CNT_W=2 instance sharing its stimulus.
module tb_ctrl_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    ctrl_decode_stage_if #(.CNT_W(8)) bus_a ();
    ctrl_decode_stage_if #(.CNT_W(2)) bus_b ();

    ctrl_decode_stage #(.DEPTH(2), .CNT_W(8)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ctrl_decode_stage #(.DEPTH(1), .CNT_W(2)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.flush_i   = bus_a.flush_i;
    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.instr     = bus_a.instr;
    assign bus_b.out_ready = bus_a.out_ready;

    always #5 clk = ~clk;

    // {RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc, Branch, Jump, JumpReg, ALUOp}
    logic [14:0] ctl_a;
    // {illegal, funct3, funct7b5, rd}
    logic [9:0]  meta_a;
    assign ctl_a  = {bus_a.RegWrite, bus_a.ImmSrc, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.MemWrite,
                     bus_a.ResultSrc, bus_a.Branch, bus_a.Jump, bus_a.JumpReg, bus_a.ALUOp};
    assign meta_a = {bus_a.illegal, bus_a.funct3, bus_a.funct7b5, bus_a.rd};

    logic [31:0] s_instr [6] = '{32'h00500093, 32'h0000A103, 32'h0020A023,
                                 32'h00208463, 32'h000080E7, 32'h123450B7};
    logic [14:0] s_ctl [6] = '{15'b1_000_00_1_0_00_0_0_0_10, 15'b1_000_00_1_0_01_0_0_0_00,
                               15'b0_001_00_1_1_00_0_0_0_00, 15'b0_010_00_0_0_00_1_0_0_01,
                               15'b1_000_00_1_0_10_0_1_1_00, 15'b1_100_10_1_0_00_0_0_0_00};
    logic [9:0]  s_meta [6] = '{10'b0_000_0_00001, 10'b0_010_0_00010, 10'b0_010_0_00000,
                                10'b0_000_0_01000, 10'b0_000_0_00001, 10'b0_101_0_00001};
    logic [31:0] sat_instr [3] = '{32'h00000000, 32'h00003003, 32'h00003023};

    logic        exp_ill;
    logic [31:0] exp_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_a.flush_i   = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.instr     = 32'h0;
        bus_a.out_ready = 1'b1;
        #1;
        chk("rst out_valid", bus_a.out_valid, 0);
        chk("rst ctl", ctl_a, 0);
        step();
        step();
        rst = 1'b0;
        chk("post-rst in_ready", bus_a.in_ready, 1);
        chk("post-rst meta", meta_a, 0);
        chk("post-rst cnt", bus_a.illegal_cnt, 0);

        // Back-to-back stream, one result per cycle
        bus_a.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_a.instr = s_instr[i];
            step();
            chk($sformatf("stream%0d valid", i), bus_a.out_valid, 1);
            chk($sformatf("stream%0d ctl", i), ctl_a, s_ctl[i]);
            chk($sformatf("stream%0d meta", i), meta_a, s_meta[i]);
        end
        bus_a.in_valid = 1'b0;
        step();
        chk("stream drained", bus_a.out_valid, 0);
        chk("stream cnt", bus_a.illegal_cnt, 0);

        // Illegal opcode, then OP with funct7=0000001
        bus_a.in_valid = 1'b1;
        bus_a.instr    = 32'h0000007F;
        step();
        chk("ill opc flag", bus_a.illegal, 1);
        chk("ill opc ctl", ctl_a, 0);
        chk("ill opc cnt", bus_a.illegal_cnt, 1);
        bus_a.instr = 32'h022080B3;
        step();
        chk("ill f7 flag", bus_a.illegal, 1);
        chk("ill f7 ctl", ctl_a, 0);
        chk("ill f7 cnt", bus_a.illegal_cnt, 2);
        chk("ill f7 cnt_b", bus_b.illegal_cnt, 2);

        // Three more illegal pushes: 2-bit counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            bus_a.instr = sat_instr[i];
            step();
            chk($sformatf("sat%0d flag", i), bus_a.illegal, 1);
            chk($sformatf("sat%0d cnt_a", i), bus_a.illegal_cnt, 3 + i);
            chk($sformatf("sat%0d cnt_b", i), bus_b.illegal_cnt, 3);
        end
        bus_a.in_valid = 1'b0;
        step();
        chk("sat drained", bus_a.out_valid, 0);

        // Backpressure: 3 stalled cycles with continuous input
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.instr     = s_instr[0];
        step();
        chk("stall1 in_ready", bus_a.in_ready, 1);
        chk("stall1 d1 in_ready", bus_b.in_ready, 0);
        chk("stall1 head", meta_a, s_meta[0]);
        bus_a.instr = s_instr[1];
        step();
        chk("stall2 in_ready", bus_a.in_ready, 0);
        chk("stall2 head", meta_a, s_meta[0]);
        bus_a.instr = s_instr[2];
        step();
        chk("stall3 in_ready", bus_a.in_ready, 0);
        chk("stall3 head meta", meta_a, s_meta[0]);
        chk("stall3 head ctl", ctl_a, s_ctl[0]);
        bus_a.out_ready = 1'b1;
        #1;
        chk("release d1 in_ready", bus_b.in_ready, 1);
        step();
        chk("release1 head", meta_a, s_meta[1]);
        chk("release1 in_ready", bus_a.in_ready, 1);
        step();
        chk("release2 head", meta_a, s_meta[2]);
        chk("release2 ctl", ctl_a, s_ctl[2]);
        bus_a.in_valid = 1'b0;
        step();
        chk("release drained", bus_a.out_valid, 0);

        // Flush with one entry while an accepted illegal input is offered
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.instr     = s_instr[0];
        step();
        bus_a.instr   = 32'h0000007F;
        bus_a.flush_i = 1'b1;
        step();
        bus_a.flush_i  = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("flush1 out_valid", bus_a.out_valid, 0);
        chk("flush1 in_ready", bus_a.in_ready, 1);
        chk("flush1 cnt", bus_a.illegal_cnt, 5);

        // Flush while full
        bus_a.in_valid = 1'b1;
        bus_a.instr    = s_instr[0];
        step();
        bus_a.instr = s_instr[1];
        step();
        chk("full in_ready", bus_a.in_ready, 0);
        bus_a.instr   = 32'h0000007F;
        bus_a.flush_i = 1'b1;
        step();
        bus_a.flush_i  = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("flush2 out_valid", bus_a.out_valid, 0);
        chk("flush2 in_ready", bus_a.in_ready, 1);
        chk("flush2 cnt", bus_a.illegal_cnt, 5);
        step();
        chk("flush2 stays empty", bus_a.out_valid, 0);

        // ECALL legality follows the SYSTEM build option
`ifdef CTRL_DECODE_SYSTEM_EN
        exp_ill = 1'b0;
        exp_cnt = 5;
`else
        exp_ill = 1'b1;
        exp_cnt = 6;
`endif
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.instr     = 32'h00000073;
        step();
        bus_a.in_valid = 1'b0;
        chk("ecall meta", meta_a, {exp_ill, 9'b0});
        chk("ecall ctl", ctl_a, 0);
        chk("ecall cnt", bus_a.illegal_cnt, exp_cnt);

        // Asynchronous reset in the middle of a cycle
        bus_a.in_valid = 1'b1;
        bus_a.instr    = s_instr[5];
        step();
        chk("pre-arst valid", bus_a.out_valid, 1);
        #2;
        rst            = 1'b1;
        bus_a.in_valid = 1'b0;
        #1;
        chk("arst out_valid", bus_a.out_valid, 0);
        chk("arst ctl", ctl_a, 0);
        chk("arst meta", meta_a, 0);
        chk("arst cnt_a", bus_a.illegal_cnt, 0);
        chk("arst cnt_b", bus_b.illegal_cnt, 0);
        step();
        rst = 1'b0;
        chk("arst release in_ready", bus_a.in_ready, 1);
        chk("arst release d1 in_ready", bus_b.in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
